// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with step, branch, jump/call and return-address stack.
// Latency: new pc visible one rising edge after an enabled cycle; pc_seq is combinational.
// Backpressure: en = 0 stalls pc and stack; error/misalign pulses drop to 0 while stalled.
module pc_unit_ras #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                 STEP         = 4,
    parameter int                 ALIGN_BITS   = 2,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             call,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] dataInput,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err,
    output logic             misaligned
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int IW = $clog2(RAS_DEPTH);

    // Low target bits that must be zero; all-zero mask when ALIGN_BITS = 0.
    localparam logic [WIDTH-1:0] LOW_MASK   = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~LOW_MASK;

    localparam logic [1:0] OP_SEQ    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_RET    = 2'b11;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ras_err_q, ras_err_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             push;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] top_val;

    assign full    = (cnt_q == CW'(RAS_DEPTH));
    assign empty   = (cnt_q == '0);
    assign top_val = ras_q[IW'(cnt_q - CW'(1))];
    assign pc_seq  = pc_q + WIDTH'(STEP);

    // Next-state selection: enable gates everything, then op picks the source.
    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        ras_err_d = 1'b0;
        mis_d     = 1'b0;
        push      = 1'b0;
        target    = '0;
        if (en) begin
            case (op)
                OP_SEQ: begin
                    pc_d = pc_seq;
                end
                OP_BRANCH: begin
                    target = pc_q + offset;
                    pc_d   = target & ALIGN_MASK;
                    mis_d  = |(target & LOW_MASK);
                end
                OP_JUMP: begin
                    target = dataInput;
                    pc_d   = target & ALIGN_MASK;
                    mis_d  = |(target & LOW_MASK);
                    if (call) begin
                        push = 1'b1;
                        // A full stack drops its oldest entry; depth stays put.
                        if (full) begin
                            ras_err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                OP_RET: begin
                    // Empty-stack return degrades to a sequential step.
                    if (empty) begin
                        pc_d      = pc_seq;
                        ras_err_d = 1'b1;
                    end else begin
                        pc_d  = top_val & ALIGN_MASK;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // Control state: pc, stack depth and the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_VECTOR;
            cnt_q     <= '0;
            ras_err_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            ras_err_q <= ras_err_d;
            mis_q     <= mis_d;
        end
    end

    // Stack storage: write at top, or shift out the oldest entry when full.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            if (full) begin
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    ras_q[i] <= ras_q[i+1];
                end
                ras_q[RAS_DEPTH-1] <= pc_seq;
            end else begin
                ras_q[IW'(cnt_q)] <= pc_seq;
            end
        end
    end

    assign pc         = pc_q;
    assign ras_empty  = empty;
    assign ras_full   = full;
    assign ras_err    = ras_err_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios followed by randomized traffic.
// Expected values come from a queue-based model updated once per clock edge.
// Every cycle after the first reset, all outputs are compared on the falling edge.
module tb_pc_unit_ras;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic        call;
    logic [31:0] offset;
    logic [31:0] dataInput;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;
    logic        misaligned;

    pc_unit_ras #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .STEP(4), .ALIGN_BITS(2), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .call(call),
        .offset(offset), .dataInput(dataInput),
        .pc(pc), .pc_seq(pc_seq), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_err(ras_err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stack [$];
    logic        m_err;
    logic        m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of architectural behaviour to the model.
    task automatic model_apply(input logic r, input logic e, input logic [1:0] o,
                               input logic c, input logic [31:0] off, input logic [31:0] dat);
        logic [31:0] t;
        logic [31:0] old_pc;
        old_pc = m_pc;
        m_err  = 0;
        m_mis  = 0;
        if (!r) begin
            m_pc = 32'h0;
            m_stack.delete();
        end else if (e) begin
            case (o)
                2'd0: m_pc = old_pc + 32'd4;
                2'd1: begin
                    t     = old_pc + off;
                    m_mis = (t % 4) != 0;
                    m_pc  = t - (t % 4);
                end
                2'd2: begin
                    t     = dat;
                    m_mis = (t % 4) != 0;
                    m_pc  = t - (t % 4);
                    if (c) begin
                        if (m_stack.size() == DEPTH) begin
                            void'(m_stack.pop_front());
                            m_err = 1;
                        end
                        m_stack.push_back(old_pc + 32'd4);
                    end
                end
                default: begin
                    if (m_stack.size() == 0) begin
                        m_pc  = old_pc + 32'd4;
                        m_err = 1;
                    end else begin
                        t    = m_stack.pop_back();
                        m_pc = t - (t % 4);
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] o,
                        input logic c, input logic [31:0] off, input logic [31:0] dat);
        @(negedge clk);
        rst = r; en = e; op = o; call = c; offset = off; dataInput = dat;
        @(posedge clk);
        #1;
        model_apply(r, e, o, c, off, dat);
        checking = 1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("pc", pc, m_pc);
            chk("pc_seq", pc_seq, m_pc + 32'd4);
            chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_stack.size() == 0});
            chk("ras_full", {31'd0, ras_full}, {31'd0, m_stack.size() == DEPTH});
            chk("ras_err", {31'd0, ras_err}, {31'd0, m_err});
            chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        end
    end

    localparam logic [1:0] SEQ = 2'd0, BR = 2'd1, JMP = 2'd2, RET = 2'd3;

    initial begin
        rst = 0; en = 0; op = SEQ; call = 0; offset = 0; dataInput = 0;
        m_pc = 0; m_err = 0; m_mis = 0;

        // Reset and sequential run
        step(0, 1, SEQ, 0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", {31'd0, ras_empty}, 32'd1);
        step(1, 1, SEQ, 0, 0, 0); chk("seq_pc1", pc, 32'h4);
        step(1, 1, SEQ, 0, 0, 0); chk("seq_pc2", pc, 32'h8);
        step(1, 1, SEQ, 0, 0, 0); chk("seq_pc3", pc, 32'hC);
        chk("seq_model", m_pc, 32'hC);

        // Stall
        step(1, 1, SEQ, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, JMP, 0, 0, 32'h80);
            chk("stall_pc", pc, 32'h10);
        end
        step(1, 1, JMP, 0, 0, 32'h80); chk("stall_release", pc, 32'h80);

        // Branch with wrap and alignment
        step(1, 1, JMP, 0, 0, 32'h8);
        step(1, 1, BR, 0, 32'hFFFF_FFF4, 0);
        chk("br_wrap", pc, 32'hFFFF_FFFC);
        chk("br_wrap_mis", {31'd0, misaligned}, 32'd0);
        step(1, 1, JMP, 0, 0, 32'h20);
        step(1, 1, BR, 0, 32'h6, 0);
        chk("br_mis_pc", pc, 32'h24);
        chk("br_mis", {31'd0, misaligned}, 32'd1);
        step(1, 1, SEQ, 0, 0, 0);
        chk("br_mis_clear", {31'd0, misaligned}, 32'd0);

        // Call/return nesting
        step(1, 1, JMP, 0, 0, 32'h100);
        step(1, 1, JMP, 1, 0, 32'h200);
        step(1, 1, JMP, 1, 0, 32'h300);
        step(1, 1, RET, 0, 0, 0); chk("ret1", pc, 32'h204);
        step(1, 1, RET, 0, 0, 0); chk("ret2", pc, 32'h104);
        chk("ret_empty", {31'd0, ras_empty}, 32'd1);

        // Overflow: five pushes into four entries
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, JMP, 1, 0, 32'(i) << 12);
        end
        chk("ovf_err", {31'd0, ras_err}, 32'd1);
        chk("ovf_full", {31'd0, ras_full}, 32'd1);
        for (int i = 4; i >= 1; i--) begin
            step(1, 1, RET, 0, 0, 0);
            chk("ovf_ret", pc, (32'(i) << 12) + 32'h4);
        end
        step(1, 1, RET, 0, 0, 0);
        chk("underflow_pc", pc, 32'h1008);
        chk("underflow_err", {31'd0, ras_err}, 32'd1);

        // Reset mid-stack
        step(1, 1, JMP, 1, 0, 32'h400);
        step(1, 1, JMP, 1, 0, 32'h500);
        step(0, 1, RET, 0, 0, 0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_empty", {31'd0, ras_empty}, 32'd1);
        step(1, 1, RET, 0, 0, 0);
        chk("midrst_ret_pc", pc, 32'h4);
        chk("midrst_ret_err", {31'd0, ras_err}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r, e, c;
            logic [1:0]  o;
            logic [31:0] off, dat;
            r   = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 9) < 8);
            o   = 2'($urandom_range(0, 3));
            c   = 1'($urandom_range(0, 1));
            off = 32'($urandom_range(0, 511)) - 32'd256;
            dat = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 4);
            step(r, e, o, c, off, dat);
        end

        @(negedge clk);
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
